axi_mport_arb: RTL and testbench

Parametrised N-port AXI4 master arbiter. It merges the per-cache AXI master ports of one or more cores (icache, dcache, …) onto a single downstream AXI4 master. AR and AW/W channels are arbitrated independently. The upstream port index is prepended to the transaction ID so that R and B responses are routed back by ID. It sits between the core/cache cluster and the system interconnect, replacing separate i/d AXI ports.

---
 rtl/axi_mport_arb.sv | 219 +++++++++++++++++++++
 tb/tb_axi_mport_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mport_arb.sv
// N-port AXI4 master arbiter: AR and AW/W arbitrated independently, R/B routed by ID prefix.
// Define AXI_MPORT_ARB_RR_EN for round-robin arbitration; fixed priority (port 0 first) otherwise.
module axi_mport_arb #(
   parameter int NUM_PORTS = 2,
   parameter int PORT_W    = 1,
   parameter int ID_W      = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_PORTS-1:0]      s_arvalid_i,
   output logic [NUM_PORTS-1:0]      s_arready_o,
   input  logic [32*NUM_PORTS-1:0]   s_araddr_i,
   input  logic [ID_W*NUM_PORTS-1:0] s_arid_i,
   input  logic [8*NUM_PORTS-1:0]    s_arlen_i,
   input  logic [2*NUM_PORTS-1:0]    s_arburst_i,
   output logic [NUM_PORTS-1:0]      s_rvalid_o,
   input  logic [NUM_PORTS-1:0]      s_rready_i,
   output logic [31:0]               s_rdata_o,
   output logic [1:0]                s_rresp_o,
   output logic [ID_W-1:0]           s_rid_o,
   output logic                      s_rlast_o,
   input  logic [NUM_PORTS-1:0]      s_awvalid_i,
   output logic [NUM_PORTS-1:0]      s_awready_o,
   input  logic [32*NUM_PORTS-1:0]   s_awaddr_i,
   input  logic [ID_W*NUM_PORTS-1:0] s_awid_i,
   input  logic [8*NUM_PORTS-1:0]    s_awlen_i,
   input  logic [2*NUM_PORTS-1:0]    s_awburst_i,
   input  logic [NUM_PORTS-1:0]      s_wvalid_i,
   output logic [NUM_PORTS-1:0]      s_wready_o,
   input  logic [32*NUM_PORTS-1:0]   s_wdata_i,
   input  logic [4*NUM_PORTS-1:0]    s_wstrb_i,
   input  logic [NUM_PORTS-1:0]      s_wlast_i,
   output logic [NUM_PORTS-1:0]      s_bvalid_o,
   input  logic [NUM_PORTS-1:0]      s_bready_i,
   output logic [1:0]                s_bresp_o,
   output logic [ID_W-1:0]           s_bid_o,
   output logic                      m_arvalid_o,
   input  logic                      m_arready_i,
   output logic [31:0]               m_araddr_o,
   output logic [ID_W+PORT_W-1:0]    m_arid_o,
   output logic [7:0]                m_arlen_o,
   output logic [1:0]                m_arburst_o,
   output logic                      m_awvalid_o,
   input  logic                      m_awready_i,
   output logic [31:0]               m_awaddr_o,
   output logic [ID_W+PORT_W-1:0]    m_awid_o,
   output logic [7:0]                m_awlen_o,
   output logic [1:0]                m_awburst_o,
   output logic                      m_wvalid_o,
   input  logic                      m_wready_i,
   output logic [31:0]               m_wdata_o,
   output logic [3:0]                m_wstrb_o,
   output logic                      m_wlast_o,
   input  logic                      m_rvalid_i,
   output logic                      m_rready_o,
   input  logic [31:0]               m_rdata_i,
   input  logic [1:0]                m_rresp_i,
   input  logic [ID_W+PORT_W-1:0]    m_rid_i,
   input  logic                      m_rlast_i,
   input  logic                      m_bvalid_i,
   output logic                      m_bready_o,
   input  logic [1:0]                m_bresp_i,
   input  logic [ID_W+PORT_W-1:0]    m_bid_i
);

   localparam int NS = 1 << PORT_W;

   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wstate_t;

   // First requester at or after last+1, wrapping at NUM_PORTS-1.
   function automatic logic [PORT_W-1:0] pick(input logic [NUM_PORTS-1:0] req,
                                              input logic [PORT_W-1:0] last);
      int best;
      int d;
      pick = '0;
      best = NUM_PORTS;
      for (int i = 0; i < NUM_PORTS; i++) begin
         d = (i + NUM_PORTS - 1 - int'(last)) % NUM_PORTS;
         if (req[i] && d < best) begin
            best = d;
            pick = PORT_W'(i);
         end
      end
   endfunction

   logic [PORT_W-1:0] ar_ptr, aw_ptr, ar_win, aw_win, wport, rq, bq;
   logic              ar_gnt, aw_gnt, w_act, w_beat, w_end, w_done;
   logic [NS-1:0]     ok, wv, wl, rr, br;
   logic [NS-1:0]     ar_oh, aw_oh, wr_oh, rv_oh, bv_oh;
   wstate_t           wst;

   for (genvar g = 0; g < NS; g++) begin : g_ok
      assign ok[g] = (g < NUM_PORTS);
   end

   assign wv = NS'(s_wvalid_i);
   assign wl = NS'(s_wlast_i);
   assign rr = NS'(s_rready_i);
   assign br = NS'(s_bready_i);

`ifdef AXI_MPORT_ARB_RR_EN
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ar_ptr <= PORT_W'(NUM_PORTS - 1);
         aw_ptr <= PORT_W'(NUM_PORTS - 1);
      end else begin
         if (ar_gnt) ar_ptr <= ar_win;
         if (aw_gnt) aw_ptr <= aw_win;
      end
   end
`else
   assign ar_ptr = PORT_W'(NUM_PORTS - 1);
   assign aw_ptr = PORT_W'(NUM_PORTS - 1);
`endif

   assign ar_win = pick(s_arvalid_i, ar_ptr);
   assign aw_win = pick(s_awvalid_i, aw_ptr);
   assign ar_gnt = !m_arvalid_o && |s_arvalid_i;
   assign aw_gnt = (wst == W_IDLE) && |s_awvalid_i;

   always_comb begin
      ar_oh = '0;
      aw_oh = '0;
      if (ar_gnt) ar_oh[ar_win] = 1'b1;
      if (aw_gnt) aw_oh[aw_win] = 1'b1;
   end

   assign s_arready_o = ar_oh[NUM_PORTS-1:0];
   assign s_awready_o = aw_oh[NUM_PORTS-1:0];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         m_arvalid_o <= 1'b0;
      end else if (ar_gnt) begin
         m_arvalid_o <= 1'b1;
         m_araddr_o  <= s_araddr_i[ar_win*32 +: 32];
         m_arid_o    <= {ar_win, s_arid_i[ar_win*ID_W +: ID_W]};
         m_arlen_o   <= s_arlen_i[ar_win*8 +: 8];
         m_arburst_o <= s_arburst_i[ar_win*2 +: 2];
      end else if (m_arready_i) begin
         m_arvalid_o <= 1'b0;
      end
   end

   // w_done covers a burst that completes while AW is still stalled.
   assign w_act  = (wst != W_IDLE) && !w_done;
   assign w_beat = w_act && wv[wport] && m_wready_i;
   assign w_end  = w_beat && wl[wport];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wst         <= W_IDLE;
         m_awvalid_o <= 1'b0;
         w_done      <= 1'b0;
      end else begin
         unique case (wst)
            W_IDLE: if (aw_gnt) begin
               wst         <= W_ADDR;
               wport       <= aw_win;
               w_done      <= 1'b0;
               m_awvalid_o <= 1'b1;
               m_awaddr_o  <= s_awaddr_i[aw_win*32 +: 32];
               m_awid_o    <= {aw_win, s_awid_i[aw_win*ID_W +: ID_W]};
               m_awlen_o   <= s_awlen_i[aw_win*8 +: 8];
               m_awburst_o <= s_awburst_i[aw_win*2 +: 2];
            end
            W_ADDR: begin
               if (w_end) w_done <= 1'b1;
               if (m_awready_i) begin
                  m_awvalid_o <= 1'b0;
                  wst <= (w_done || w_end) ? W_IDLE : W_DATA;
               end
            end
            W_DATA: if (w_end) wst <= W_IDLE;
            default: wst <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_oh = '0;
      if (w_act) wr_oh[wport] = m_wready_i;
   end

   assign s_wready_o = wr_oh[NUM_PORTS-1:0];
   assign m_wvalid_o = w_act && wv[wport];
   assign m_wdata_o  = s_wdata_i[wport*32 +: 32];
   assign m_wstrb_o  = s_wstrb_i[wport*4 +: 4];
   assign m_wlast_o  = wl[wport];

   assign rq = m_rid_i[ID_W +: PORT_W];
   assign bq = m_bid_i[ID_W +: PORT_W];

   // Responses carrying a port index with no upstream port are sunk.
   always_comb begin
      rv_oh      = '0;
      bv_oh      = '0;
      m_rready_o = 1'b1;
      m_bready_o = 1'b1;
      if (ok[rq]) begin
         rv_oh[rq]  = m_rvalid_i;
         m_rready_o = rr[rq];
      end
      if (ok[bq]) begin
         bv_oh[bq]  = m_bvalid_i;
         m_bready_o = br[bq];
      end
   end

   assign s_rvalid_o = rv_oh[NUM_PORTS-1:0];
   assign s_bvalid_o = bv_oh[NUM_PORTS-1:0];
   assign s_rdata_o  = m_rdata_i;
   assign s_rresp_o  = m_rresp_i;
   assign s_rid_o    = m_rid_i[ID_W-1:0];
   assign s_rlast_o  = m_rlast_i;
   assign s_bresp_o  = m_bresp_i;
   assign s_bid_o    = m_bid_i[ID_W-1:0];

endmodule

// File: tb/tb_axi_mport_arb.sv
// Scoreboard bench for axi_mport_arb: 2 ports, 2-bit port field so bad IDs can be driven.
// Expected AR/AW/W/R/B traffic is queued by stimulus and popped by a negedge monitor.
module tb_axi_mport_arb;

   localparam int NP = 2;
   localparam int PW = 2;
   localparam int IW = 4;
   localparam int DW = IW + PW;

   logic clk = 1'b0;
   logic rst_i;
   logic [NP-1:0]    s_arvalid_i, s_arready_o;
   logic [32*NP-1:0] s_araddr_i;
   logic [IW*NP-1:0] s_arid_i;
   logic [8*NP-1:0]  s_arlen_i;
   logic [2*NP-1:0]  s_arburst_i;
   logic [NP-1:0]    s_rvalid_o, s_rready_i;
   logic [31:0]      s_rdata_o;
   logic [1:0]       s_rresp_o;
   logic [IW-1:0]    s_rid_o;
   logic             s_rlast_o;
   logic [NP-1:0]    s_awvalid_i, s_awready_o;
   logic [32*NP-1:0] s_awaddr_i;
   logic [IW*NP-1:0] s_awid_i;
   logic [8*NP-1:0]  s_awlen_i;
   logic [2*NP-1:0]  s_awburst_i;
   logic [NP-1:0]    s_wvalid_i, s_wready_o;
   logic [32*NP-1:0] s_wdata_i;
   logic [4*NP-1:0]  s_wstrb_i;
   logic [NP-1:0]    s_wlast_i;
   logic [NP-1:0]    s_bvalid_o, s_bready_i;
   logic [1:0]       s_bresp_o;
   logic [IW-1:0]    s_bid_o;
   logic             m_arvalid_o, m_arready_i;
   logic [31:0]      m_araddr_o;
   logic [DW-1:0]    m_arid_o;
   logic [7:0]       m_arlen_o;
   logic [1:0]       m_arburst_o;
   logic             m_awvalid_o, m_awready_i;
   logic [31:0]      m_awaddr_o;
   logic [DW-1:0]    m_awid_o;
   logic [7:0]       m_awlen_o;
   logic [1:0]       m_awburst_o;
   logic             m_wvalid_o, m_wready_i;
   logic [31:0]      m_wdata_o;
   logic [3:0]       m_wstrb_o;
   logic             m_wlast_o;
   logic             m_rvalid_i, m_rready_o;
   logic [31:0]      m_rdata_i;
   logic [1:0]       m_rresp_i;
   logic [DW-1:0]    m_rid_i;
   logic             m_rlast_i;
   logic             m_bvalid_i, m_bready_o;
   logic [1:0]       m_bresp_i;
   logic [DW-1:0]    m_bid_i;

   axi_mport_arb #(.NUM_PORTS(NP), .PORT_W(PW), .ID_W(IW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
      .s_araddr_i(s_araddr_i), .s_arid_i(s_arid_i),
      .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
      .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
      .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o),
      .s_rid_o(s_rid_o), .s_rlast_o(s_rlast_o),
      .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
      .s_awaddr_i(s_awaddr_i), .s_awid_i(s_awid_i),
      .s_awlen_i(s_awlen_i), .s_awburst_i(s_awburst_i),
      .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
      .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
      .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
      .s_bresp_o(s_bresp_o), .s_bid_o(s_bid_o),
      .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
      .m_araddr_o(m_araddr_o), .m_arid_o(m_arid_o),
      .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
      .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
      .m_awaddr_o(m_awaddr_o), .m_awid_o(m_awid_o),
      .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o),
      .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
      .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
      .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
      .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
      .m_rid_i(m_rid_i), .m_rlast_i(m_rlast_i),
      .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
      .m_bresp_i(m_bresp_i), .m_bid_i(m_bid_i)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [5:0]  id;
      logic [7:0]  len;
      logic [1:0]  burst;
   } ar_t;

   typedef struct packed {
      logic [31:0] a;
      logic [5:0]  id;
      logic [7:0]  len;
      logic [7:0]  wb;
   } aw_t;

   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } w_t;

   typedef struct packed {
      logic [1:0]  v;
      logic [3:0]  id;
      logic        rdy;
      logic [31:0] d;
   } rs_t;

   ar_t ar_q[$];
   aw_t aw_q[$];
   w_t  w_q[$];
   rs_t r_q[$];
   rs_t b_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] w_cnt = '0;

   function automatic void chk(input string nm, input logic [63:0] act,
                               input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // Monitor: pops expectations whenever the DUT presents traffic.
   always @(negedge clk) begin
      if (rst_i) begin
         if (m_arvalid_o && m_arready_i) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("ar_beat", {m_araddr_o, m_arid_o, m_arlen_o, m_arburst_o},
                     ar_q.pop_front());
         end
         if (m_awvalid_o && m_awready_i) begin
            if (aw_q.size() == 0) chk("aw_unexpected", 1, 0);
            else chk("aw_beat", {m_awaddr_o, m_awid_o, m_awlen_o, w_cnt},
                     aw_q.pop_front());
         end
         if (m_wvalid_o && m_wready_i) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_q.size() == 0) chk("w_unexpected", 1, 0);
            else chk("w_beat", {m_wdata_o, m_wlast_o}, w_q.pop_front());
         end
         if (m_rvalid_i) begin
            if (r_q.size() == 0) chk("r_unexpected", 1, 0);
            else chk("r_route", {s_rvalid_o, s_rid_o, m_rready_o, s_rdata_o},
                     r_q.pop_front());
         end
         if (m_bvalid_i) begin
            if (b_q.size() == 0) chk("b_unexpected", 1, 0);
            else chk("b_route", {s_bvalid_o, s_bid_o, m_bready_o, 30'd0, s_bresp_o},
                     b_q.pop_front());
         end
      end
   end

   task automatic ar_req(input int p, input logic [31:0] a, input logic [3:0] id,
                         input bit keep);
      int g;
      g = 0;
      s_araddr_i[p*32 +: 32] = a;
      s_arid_i[p*4 +: 4]     = id;
      s_arlen_i[p*8 +: 8]    = 8'd0;
      s_arburst_i[p*2 +: 2]  = 2'b01;
      s_arvalid_i[p]         = 1'b1;
      do begin @(negedge clk); g++; end while (!s_arready_o[p] && g < 20);
      chk("ar_grant", s_arready_o[p], 1);
      @(posedge clk); #1;
      if (!keep) s_arvalid_i[p] = 1'b0;
   endtask

   task automatic aw_req(input int p, input logic [31:0] a, input logic [3:0] id,
                         input logic [7:0] len, input int lim);
      int g;
      g = 0;
      s_awaddr_i[p*32 +: 32] = a;
      s_awid_i[p*4 +: 4]     = id;
      s_awlen_i[p*8 +: 8]    = len;
      s_awburst_i[p*2 +: 2]  = 2'b01;
      s_awvalid_i[p]         = 1'b1;
      do begin @(negedge clk); g++; end while (!s_awready_o[p] && g < lim);
      chk("aw_grant", s_awready_o[p], 1);
      @(posedge clk); #1;
      s_awvalid_i[p] = 1'b0;
   endtask

   task automatic send_w(input int p, input int n, input logic [31:0] base,
                         input bit toggle, input int total);
      int g;
      bit hs;
      for (int b = 0; b < n; b++) begin
         s_wdata_i[p*32 +: 32] = base + 32'(b);
         s_wstrb_i[p*4 +: 4]   = 4'hf;
         s_wlast_i[p]          = (b == total - 1);
         s_wvalid_i[p]         = 1'b1;
         g = 0;
         do begin
            @(negedge clk);
            hs = s_wready_o[p];
            @(posedge clk); #1;
            if (toggle) m_wready_i = ~m_wready_i;
            g++;
         end while (!hs && g < 20);
         chk("w_accept", hs, 1);
      end
      s_wvalid_i[p] = 1'b0;
      s_wlast_i[p]  = 1'b0;
   endtask

   task automatic r_rsp(input logic [5:0] rid, input logic [1:0] rdy,
                        input logic [31:0] d, input rs_t e);
      r_q.push_back(e);
      s_rready_i = rdy;
      m_rid_i    = rid;
      m_rdata_i  = d;
      m_rlast_i  = 1'b1;
      m_rvalid_i = 1'b1;
      @(posedge clk); #1;
      m_rvalid_i = 1'b0;
   endtask

   task automatic b_rsp(input logic [5:0] bid, input logic [1:0] rdy,
                        input logic [1:0] resp, input rs_t e);
      b_q.push_back(e);
      s_bready_i = rdy;
      m_bid_i    = bid;
      m_bresp_i  = resp;
      m_bvalid_i = 1'b1;
      @(posedge clk); #1;
      m_bvalid_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst_i = 1'b0;
      s_arvalid_i = '0; s_araddr_i = '0; s_arid_i = '0;
      s_arlen_i = '0; s_arburst_i = '0;
      s_awvalid_i = '0; s_awaddr_i = '0; s_awid_i = '0;
      s_awlen_i = '0; s_awburst_i = '0;
      s_wvalid_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_wlast_i = '0;
      s_rready_i = '0; s_bready_i = '0;
      m_arready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
      m_rvalid_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0;
      m_rid_i = '0; m_rlast_i = 1'b0;
      m_bvalid_i = 1'b0; m_bresp_i = '0; m_bid_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", m_arvalid_o, 0);
      chk("rst_awvalid", m_awvalid_o, 0);
      chk("rst_arready", s_arready_o, 0);
      chk("rst_awready", s_awready_o, 0);
      chk("rst_wvalid", m_wvalid_o, 0);
      chk("rst_wready", s_wready_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b1;
      m_arready_i = 1'b1;
      m_awready_i = 1'b1;
      m_wready_i = 1'b1;

      ar_q.push_back('{32'h80000040, 6'h13, 8'd0, 2'b01});
      ar_req(1, 32'h80000040, 4'd3, 1'b0);
      @(negedge clk);
      chk("ar_latency", m_arvalid_o, 1);
      @(posedge clk); #1;
      r_rsp(6'h13, 2'b11, 32'hdeadbeef, '{2'b10, 4'd3, 1'b1, 32'hdeadbeef});
      r_rsp(6'h05, 2'b10, 32'h11112222, '{2'b01, 4'd5, 1'b0, 32'h11112222});
      r_rsp(6'h2a, 2'b00, 32'h33334444, '{2'b00, 4'ha, 1'b1, 32'h33334444});

`ifdef AXI_MPORT_ARB_RR_EN
      ar_q.push_back('{32'h1000, 6'h01, 8'd0, 2'b01});
      ar_q.push_back('{32'h2000, 6'h12, 8'd0, 2'b01});
      ar_q.push_back('{32'h1000, 6'h01, 8'd0, 2'b01});
      ar_q.push_back('{32'h2000, 6'h12, 8'd0, 2'b01});
`else
      repeat (4) ar_q.push_back('{32'h1000, 6'h01, 8'd0, 2'b01});
`endif
      s_araddr_i  = {32'h2000, 32'h1000};
      s_arid_i    = {4'd2, 4'd1};
      s_arlen_i   = '0;
      s_arburst_i = {2'b01, 2'b01};
      s_arvalid_i = 2'b11;
      for (int g = 0; g < 4; g++) begin
         t = 0;
         do begin @(negedge clk); t++; end while (s_arready_o == '0 && t < 10);
         chk("contend_grant", 64'(|s_arready_o), 1);
         @(posedge clk);
      end
      #1 s_arvalid_i = '0;
      repeat (3) @(posedge clk);
      #1;

      m_arready_i = 1'b0;
      ar_q.push_back('{32'h3000, 6'h05, 8'd0, 2'b01});
      ar_q.push_back('{32'h3004, 6'h06, 8'd0, 2'b01});
      ar_req(0, 32'h3000, 4'd5, 1'b1);
      s_araddr_i[31:0] = 32'h3004;
      s_arid_i[3:0]    = 4'd6;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold", {m_arvalid_o, m_araddr_o, s_arready_o}, {1'b1, 32'h3000, 2'b00});
      end
      @(posedge clk); #1;
      m_arready_i = 1'b1;
      ar_req(0, 32'h3004, 4'd6, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      aw_q.push_back('{32'h4000, 6'h01, 8'd3, 8'd0});
      aw_q.push_back('{32'h5000, 6'h12, 8'd0, 8'd4});
      for (int b = 0; b < 4; b++) w_q.push_back('{32'ha0 + 32'(b), b == 3});
      w_q.push_back('{32'hb0, 1'b1});
      fork
         begin
            aw_req(0, 32'h4000, 4'd1, 8'd3, 20);
            send_w(0, 4, 32'ha0, 1'b1, 4);
            m_wready_i = 1'b1;
         end
         begin
            aw_req(1, 32'h5000, 4'd2, 8'd0, 60);
            send_w(1, 1, 32'hb0, 1'b0, 1);
         end
      join
      repeat (2) @(posedge clk);
      #1;

      b_rsp(6'h37, 2'b00, 2'b00, '{2'b00, 4'd7, 1'b1, 32'd0});
      b_rsp(6'h12, 2'b10, 2'b10, '{2'b10, 4'd2, 1'b1, 32'd2});

      aw_q.push_back('{32'h4100, 6'h01, 8'd3, 8'd5});
      w_q.push_back('{32'hd0, 1'b0});
      w_q.push_back('{32'hd1, 1'b0});
      aw_req(0, 32'h4100, 4'd1, 8'd3, 20);
      send_w(0, 2, 32'hd0, 1'b0, 4);
      s_wdata_i[31:0] = 32'hd2;
      s_wvalid_i[0] = 1'b1;
      m_wready_i = 1'b0;
      rst_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_wvalid", m_wvalid_o, 0);
      chk("rst_mid_awvalid", m_awvalid_o, 0);
      chk("rst_mid_wready", s_wready_o, 0);
      @(posedge clk); #1;
      rst_i = 1'b1;
      s_wvalid_i = '0;
      m_wready_i = 1'b1;

      aw_q.push_back('{32'h6000, 6'h14, 8'd0, 8'd7});
      w_q.push_back('{32'he0, 1'b1});
      aw_req(1, 32'h6000, 4'd4, 8'd0, 20);
      send_w(1, 1, 32'he0, 1'b0, 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("ar_q_empty", ar_q.size(), 0);
      chk("aw_q_empty", aw_q.size(), 0);
      chk("w_q_empty", w_q.size(), 0);
      chk("r_q_empty", r_q.size(), 0);
      chk("b_q_empty", b_q.size(), 0);
      chk("w_count", w_cnt, 8);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
